// File: rtl/imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl
//
// Loads a program into the instruction memory from a byte-wide host stream
// while holding the CPU in reset. When idle (RUN), the memory port is handed
// to the CPU fetch path. During a load, four host bytes are assembled
// big-endian into one 32-bit word, written in a single WRITE cycle, and the
// process repeats until the requested word count is written. Two DRAIN
// cycles follow before the CPU is released, and done pulses on the last one.
//
// Ports
//   clk       : single clock, rising-edge active
//   rst       : synchronous, active-high reset
//   ld_start  : one-cycle request to begin (or restart) a load
//   ld_len    : words to load, sampled with ld_start (0 means 2**AW)
//   ld_valid  : host byte present
//   ld_byte   : host byte
//   ld_ready  : block accepts a byte when ld_valid && ld_ready
//   cpu_pc    : CPU fetch address (byte address)
//   cpu_inst  : instruction returned to the CPU (nop while loading)
//   cpu_rst   : holds the CPU in reset while loading
//   mem_a     : instruction-memory word address
//   mem_we    : instruction-memory write enable
//   mem_wd    : instruction-memory write data
//   mem_rd    : asynchronous instruction-memory read data
//   done      : one-cycle pulse when a load completes
// ---------------------------------------------------------------------------
module imem_load_ctrl #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic [AW:0]   ld_len,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  output logic          ld_ready,
  input  logic [31:0]   cpu_pc,
  output logic [31:0]   cpu_inst,
  output logic          cpu_rst,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd,
  output logic          done
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [AW-1:0] word_cnt;
  logic [AW:0]   len_reg;
  logic [31:0]   asm_reg;
  logic          drain_cnt;

  // Index of the final word. Truncating len_reg-1 to AW bits maps a length
  // of 0 (and of 2**AW) onto the top address, so a full load needs no
  // special case and word_cnt can never wrap past the top address.
  logic [AW-1:0] last_idx;
  assign last_idx = AW'(len_reg - (AW+1)'(1));

  // Only the word-address bits of the fetch address reach the memory.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{cpu_pc[31:AW+2], cpu_pc[1:0]};

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      len_reg   <= '0;
      asm_reg   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ld_start) begin
            state    <= LOAD;
            byte_cnt <= '0;
            word_cnt <= '0;
            len_reg  <= ld_len;
            asm_reg  <= '0;
          end
        end

        LOAD: begin
          // A restart takes priority over a byte offered in the same cycle.
          if (ld_start) begin
            byte_cnt <= '0;
            word_cnt <= '0;
            len_reg  <= ld_len;
            asm_reg  <= '0;
          end else if (ld_valid) begin
            asm_reg  <= {asm_reg[23:0], ld_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= WRITE;
            end
          end
        end

        WRITE: begin
          if (ld_start) begin
            state    <= LOAD;
            byte_cnt <= '0;
            word_cnt <= '0;
            len_reg  <= ld_len;
            asm_reg  <= '0;
          end else if (word_cnt == last_idx) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            word_cnt <= word_cnt + AW'(1);
            state    <= LOAD;
          end
        end

        DRAIN: begin
          // ld_start is deliberately ignored here.
          if (drain_cnt) begin
            state     <= RUN;
            drain_cnt <= 1'b0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end

        default: state <= RUN;
      endcase
    end
  end

  // While rst is applied the outputs already present the RUN view, so a
  // reset mid-load releases the CPU and blocks writes in the same cycle.
  logic run_view;
  assign run_view = rst || (state == RUN);

  assign mem_a    = run_view ? cpu_pc[AW+1:2] : word_cnt;
  assign cpu_inst = run_view ? mem_rd : 32'h0000_0000;
  assign cpu_rst  = !run_view;
  assign ld_ready = !rst && (state == LOAD);
  // A restart requested during WRITE suppresses that cycle's write.
  assign mem_we   = !rst && (state == WRITE) && !ld_start;
  assign mem_wd   = asm_reg;
  assign done     = !rst && (state == DRAIN) && drain_cnt;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_load_ctrl
//
// Self-checking bench for imem_load_ctrl. Provides a behavioural instruction
// memory, drives directed loads with random program bytes, and compares the
// observed writes, handshakes and fetch results against a reference model
// that derives the expected memory image straight from the byte stream.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_imem_load_ctrl;

  localparam int AW    = 7;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_start;
  logic [AW:0]   ld_len;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_ready;
  logic [31:0]   cpu_pc;
  logic [31:0]   cpu_inst;
  logic          cpu_rst;
  logic [AW-1:0] mem_a;
  logic          mem_we;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;
  logic          done;

  always #5 clk = ~clk;

  imem_load_ctrl #(.AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_start (ld_start),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_ready (ld_ready),
    .cpu_pc   (cpu_pc),
    .cpu_inst (cpu_inst),
    .cpu_rst  (cpu_rst),
    .mem_a    (mem_a),
    .mem_we   (mem_we),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd),
    .done     (done)
  );

  // Behavioural instruction memory: asynchronous read, synchronous write.
  logic [31:0] mem [WORDS];
  assign mem_rd = mem[mem_a];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wd;
  end

  // Reference image of what memory should hold.
  logic [31:0] ref_mem [WORDS];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t wr_q[$];   // observed writes
  wr_t exp_q[$];  // expected writes
  int  n_bytes   = 0;
  int  n_done    = 0;
  int  bad_ready = 0;

  // Passive monitor, sampling away from the active edge.
  always @(negedge clk) begin
    wr_t w;
    if (mem_we) begin
      w.a = mem_a;
      w.d = mem_wd;
      wr_q.push_back(w);
    end
    if (ld_valid && ld_ready) n_bytes++;
    if (done) n_done++;
    if (mem_we && ld_ready) bad_ready++;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [AW:0] len);
    ld_start = 1'b1;
    ld_len   = len;
    tick();
    ld_start = 1'b0;
  endtask

  // Offers one byte and returns just after the edge that accepted it.
  // ld_valid is left high so back-to-back bytes need no idle cycle.
  task automatic send_byte(input logic [7:0] b);
    bit hit;
    hit      = 1'b0;
    ld_valid = 1'b1;
    ld_byte  = b;
    for (int k = 0; k < 32 && !hit; k++) begin
      @(negedge clk);
      hit = ld_ready;
      tick();
    end
    if (!hit) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    tick();
  endtask

  // Full load with random bytes; builds the expected writes from the
  // byte stream (word i = bytes 4i..4i+3, first byte most significant).
  task automatic run_load(input logic [AW:0] len, input bit gaps);
    logic [7:0] bq[$];
    int nw;
    wr_t w;
    nw = (len == 0) ? WORDS : int'(len);
    wr_q.delete();
    exp_q.delete();
    start_load(len);
    for (int i = 0; i < 4 * nw; i++) begin
      bq.push_back(8'($urandom));
      if (gaps && $urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
        tick();
      end
      send_byte(bq[i]);
    end
    ld_valid = 1'b0;
    wait_done();
    for (int i = 0; i < nw; i++) begin
      w.a = AW'(i);
      w.d = {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]};
      exp_q.push_back(w);
      ref_mem[i] = w.d;
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      check({tag, "_addr"}, 32'(wr_q[i].a), 32'(exp_q[i].a));
      check({tag, "_data"}, wr_q[i].d, exp_q[i].d);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0, p;
    logic [31:0] w0;
    logic [7:0] rb [6];

    for (int i = 0; i < WORDS; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    rst      = 1'b1;
    ld_start = 1'b0;
    ld_len   = '0;
    ld_valid = 1'b0;
    ld_byte  = '0;
    cpu_pc   = 32'h0000_000C;

    // Reset: outputs show the RUN view while rst is applied.
    tick();
    @(negedge clk);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_mem_we",   {31'd0, mem_we},   32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_cpu_rst",  {31'd0, cpu_rst},  32'd0);
    check("rst_cpu_inst", cpu_inst, ref_mem[3]);
    tick();
    rst = 1'b0;

    // RUN fetch, including pc 0xC -> word 3.
    @(negedge clk);
    check("run_mem_a",    32'(mem_a), 32'd3);
    check("run_cpu_inst", cpu_inst, ref_mem[3]);
    for (int i = 0; i < 4; i++) begin
      tick();
      p      = $urandom_range(0, WORDS - 1);
      cpu_pc = {$urandom_range(0, 255), 24'd0} | (32'(p) << 2) | 32'($urandom_range(0, 3));
      @(negedge clk);
      check("run_rand_mem_a", 32'(mem_a), 32'(p));
      check("run_rand_inst",  cpu_inst,   ref_mem[p]);
    end
    tick();
    cpu_pc = 32'h0000_000C;

    // ld_valid in RUN consumes nothing.
    b0       = n_bytes;
    ld_valid = 1'b1;
    ld_byte  = 8'hAA;
    repeat (3) tick();
    ld_valid = 1'b0;
    check("run_no_consume", 32'(n_bytes - b0), 32'd0);

    // 1-word load, cycle-exact.
    d0 = n_done;
    wr_q.delete();
    start_load(1);
    send_byte(8'h20);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h01);
    ld_valid = 1'b0;
    @(negedge clk);
    check("w1_we",       {31'd0, mem_we},   32'd1);
    check("w1_addr",     32'(mem_a),        32'd0);
    check("w1_data",     mem_wd,            32'h2008_0001);
    check("w1_ready",    {31'd0, ld_ready}, 32'd0);
    check("w1_cpu_rst",  {31'd0, cpu_rst},  32'd1);
    check("w1_cpu_inst", cpu_inst,          32'd0);
    @(negedge clk);
    check("w1_dr1_we",   {31'd0, mem_we},   32'd0);
    check("w1_dr1_rst",  {31'd0, cpu_rst},  32'd1);
    check("w1_dr1_done", {31'd0, done},     32'd0);
    @(negedge clk);
    check("w1_dr2_rst",  {31'd0, cpu_rst},  32'd1);
    check("w1_dr2_done", {31'd0, done},     32'd1);
    @(negedge clk);
    check("w1_run_rst",  {31'd0, cpu_rst},  32'd0);
    check("w1_run_done", {31'd0, done},     32'd0);
    check("w1_nwrites",  32'(wr_q.size()),  32'd1);
    check("w1_ndone",    32'(n_done - d0),  32'd1);
    tick();
    ref_mem[0] = 32'h2008_0001;

    // Backpressure: 3 words, ld_valid held high throughout.
    b0 = n_bytes;
    run_load(3, 1'b0);
    check_writes("bp");
    check("bp_bytes",      32'(n_bytes - b0), 32'd12);
    check("bp_ready_in_wr", 32'(bad_ready),   32'd0);

    // Full 128-word load with random idle gaps; no wrap write.
    d0 = n_done;
    run_load(0, 1'b1);
    repeat (6) tick();
    check_writes("full");
    check("full_ndone", 32'(n_done - d0), 32'd1);

    // Restart in LOAD after 2 bytes of a 2-word load.
    wr_q.delete();
    start_load(2);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    ld_valid = 1'b0;
    run_load(2, 1'b0);
    check_writes("rst_load");

    // Restart during WRITE: no write that cycle, then a fresh 1-word load.
    wr_q.delete();
    start_load(2);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    ld_valid = 1'b0;
    ld_start = 1'b1;
    ld_len   = 1;
    @(negedge clk);
    check("restart_wr_we", {31'd0, mem_we}, 32'd0);
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rb[i] = 8'($urandom);
      send_byte(rb[i]);
    end
    ld_valid = 1'b0;
    wait_done();
    ref_mem[0] = {rb[0], rb[1], rb[2], rb[3]};
    check("restart_wr_n",    32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) check("restart_wr_data", wr_q[0].d, ref_mem[0]);

    // Reset mid-load after 6 bytes of a 2-word load.
    wr_q.delete();
    start_load(2);
    for (int i = 0; i < 6; i++) begin
      rb[i] = 8'($urandom);
      send_byte(rb[i]);
    end
    w0         = {rb[0], rb[1], rb[2], rb[3]};
    ref_mem[0] = w0;
    ld_valid   = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    check("mid_rst_we",   {31'd0, mem_we},  32'd0);
    check("mid_rst_cpu",  {31'd0, cpu_rst}, 32'd0);
    check("mid_rst_inst", cpu_inst, ref_mem[3]);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cpu",   {31'd0, cpu_rst},  32'd0);
    check("post_rst_we",    {31'd0, mem_we},   32'd0);
    check("post_rst_ready", {31'd0, ld_ready}, 32'd0);
    check("post_rst_nwr",   32'(wr_q.size()),  32'd1);
    tick();
    cpu_pc = 32'h0000_0000;
    @(negedge clk);
    check("post_rst_word0", cpu_inst, w0);
    tick();

    // Fresh load after reset starts from a clean byte count.
    run_load(1, 1'b0);
    check_writes("after_rst");

    // Final image via the CPU fetch path.
    for (int i = 0; i < WORDS; i++) begin
      cpu_pc = (32'(i) << 2) | 32'($urandom_range(0, 3));
      @(negedge clk);
      check("image", cpu_inst, ref_mem[i]);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter AW, default 7, meaning the instruction-memory word-address width (128 words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port ld_start, input, 1, a one-cycle request to begin a program load.
REQ-005 SHALL have port ld_len, input, AW+1, the number of words to load, sampled with ld_start; 0 means 128.
REQ-006 SHALL have port ld_valid, input, 1, meaning a host byte is present.
REQ-007 SHALL have port ld_byte, input, 8, the host byte.
REQ-008 SHALL have port ld_ready, output, 1; the block accepts a byte when ld_valid and ld_ready are both high.
REQ-009 SHALL have port cpu_pc, input, 32, the CPU fetch address.
REQ-010 SHALL have port cpu_inst, output, 32, the instruction returned to the CPU.
REQ-011 SHALL have port cpu_rst, output, 1, holding the CPU in reset.
REQ-012 SHALL have port mem_a, output, AW, the instruction-memory word address.
REQ-013 SHALL have port mem_we, output, 1, the instruction-memory write enable.
REQ-014 SHALL have port mem_wd, output, 32, the instruction-memory write data.
REQ-015 SHALL have port mem_rd, input, 32, the asynchronous instruction-memory read data.
REQ-016 SHALL have port done, output, 1, a one-cycle pulse when a load completes.

Function
REQ-017 SHALL implement states RUN, LOAD, WRITE and DRAIN.
REQ-018 In RUN: mem_a = cpu_pc[AW+1:2]; cpu_inst = mem_rd; cpu_rst = 0; ld_ready = 0; mem_we = 0.
REQ-019 In every non-RUN state: cpu_rst = 1; cpu_inst = 32'h00000000 (nop).
REQ-020 RUN with ld_start=1 SHALL go to LOAD, clear byte_cnt (2 bits) and word_cnt (AW bits), and latch ld_len into len_reg.
REQ-021 In LOAD: ld_ready = 1; each accepted byte shifts into a 32-bit assembly register big-endian (first byte lands in [31:24]); byte_cnt increments.
REQ-022 Acceptance of the 4th byte (byte_cnt==3) SHALL go to WRITE next cycle with byte_cnt wrapped to 0.
REQ-023 In WRITE (exactly one cycle): mem_we = 1; mem_a = word_cnt; mem_wd = assembly register; ld_ready = 0.
REQ-024 WRITE exit:
- if word_cnt == len_reg-1 (128 words when len_reg==0): go to DRAIN;
- otherwise: word_cnt increments and state returns to LOAD.
REQ-025 DRAIN SHALL last exactly 2 cycles with cpu_rst=1; then go to RUN, with done=1 for the single cycle that leaves DRAIN.
REQ-026 ld_start in LOAD or WRITE SHALL restart the load: counters cleared, ld_len relatched, state LOAD, no write that cycle; ld_start in DRAIN SHALL be ignored.
REQ-027 ld_valid while ld_ready=0 SHALL be ignored; no byte is consumed.
REQ-028 word_cnt SHALL never exceed 127; a 128-word load writes addresses 0..127 with no wrap write.
REQ-029 In non-WRITE, non-RUN states: mem_a = word_cnt; mem_we = 0.

Reset
REQ-030 rst=1 SHALL, at the next edge, force state RUN, byte_cnt=0, word_cnt=0, len_reg=0 and the assembly register to 0, including in the middle of a load; the partial word is discarded and memory contents are left untouched.
REQ-031 Output values with rst=1 applied: ld_ready=0, mem_we=0, done=0, cpu_rst=0, and cpu_inst = mem_rd at address cpu_pc[8:2].

Verification
REQ-032 RUN fetch: cpu_pc=32'h0000000C, mem_rd model returns word 3 -> mem_a=3 and cpu_inst equals that word in the same cycle.
REQ-033 1-word load: ld_start with ld_len=1, then bytes 20,08,00,01 -> one WRITE cycle with mem_a=0 and mem_wd=32'h20080001; 2 DRAIN cycles; done pulse; RUN.
REQ-034 Backpressure: 3-word load with ld_valid held high continuously -> ld_ready=0 during each WRITE; exactly 12 bytes consumed; writes to addresses 0,1,2.
REQ-035 Full load: ld_len=0 -> 128 writes to addresses 0..127; no 129th write; done asserted once.
REQ-036 Restart: ld_start after 2 bytes of a 2-word load -> partial bytes discarded; the next 4 bytes are written to address 0.
REQ-037 Reset mid-load: rst asserted in LOAD after 6 bytes -> next cycle in RUN with cpu_rst=0 and mem_we=0; word 0 stays as written.
